// File: rtl/lbm_moment_pipe.sv
// lbm_moment_pipe: D2Q9 rho/jx/jy moments over a 2-stage valid/ready pipe,
// with cell indexing, frame counting and a per-frame mass checksum.
module lbm_moment_pipe #(
  parameter int GRID_DIM        = 256,
  parameter int DATA_WIDTH      = 32,
  parameter int FRACTIONAL_BITS = 24,
  parameter int ADDRESS_WIDTH   = $clog2(GRID_DIM),
  parameter int DATA_WIDTH_F    = 9 * DATA_WIDTH,
  parameter int ACC_WIDTH       = DATA_WIDTH + ADDRESS_WIDTH
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH_F-1:0]  fin_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    rho_out,
  output logic [DATA_WIDTH-1:0]    jx_out,
  output logic [DATA_WIDTH-1:0]    jy_out,
  output logic [ADDRESS_WIDTH-1:0] cell_addr,
  output logic                     out_last,
  output logic [ACC_WIDTH-1:0]     mass_total,
  output logic                     mass_valid,
  output logic [15:0]              frame_count,
  output logic                     sat_err
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = DATA_WIDTH + 4;
  localparam int AW = ADDRESS_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(GRID_DIM - 1);

  if (FRACTIONAL_BITS >= DATA_WIDTH || GRID_DIM < 2) begin : g_bad_param
    $error("lbm_moment_pipe: bad FRACTIONAL_BITS or GRID_DIM");
  end

  logic signed [DW-1:0] w_f [9];

  for (genvar i = 0; i < 9; i++) begin : g_unpack
    assign w_f[i] = fin_in[i*DW +: DW];
  end

  function automatic logic signed [PW-1:0] sx(
    input logic signed [DW-1:0] v
  );
    return {{(PW-DW){v[DW-1]}}, v};
  endfunction

  // Overflow when the bits above the DW-bit sign are not a pure extension
  function automatic logic ovf(input logic signed [PW-1:0] v);
    return !((&v[PW-1:DW-1]) || !(|v[PW-1:DW-1]));
  endfunction

  function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] v);
    if (!ovf(v)) return v[DW-1:0];
    return v[PW-1] ? {1'b1, {(DW-1){1'b0}}}
                   : {1'b0, {(DW-1){1'b1}}};
  endfunction

  logic                 r_s1_valid;
  logic signed [PW-1:0] r_ra, r_rb, r_rc;
  logic signed [PW-1:0] r_xp, r_xn, r_yp, r_yn;
  logic                 r_out_valid;
  logic [DW-1:0]        r_rho, r_jx, r_jy;
  logic                 r_sat;
  logic [AW-1:0]        r_addr;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_mass_total;
  logic                 r_mass_valid;
  logic [15:0]          r_frames;

  logic                 w_adv1, w_adv2;
  logic                 w_in_fire, w_out_fire, w_last, w_s2_load;
  logic signed [PW-1:0] w_rho, w_jx, w_jy;
  logic                 w_sat;
  logic [ACC_WIDTH-1:0] w_rho_ext;

  assign w_adv2    = !r_out_valid || out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign in_ready  = RESET && w_adv1 && !clr;
  assign w_in_fire = in_valid && in_ready;
  assign w_s2_load = !clr && w_adv2 && r_s1_valid;

  assign w_rho = r_ra + r_rb + r_rc;
  assign w_jx  = r_xp - r_xn;
  assign w_jy  = r_yp - r_yn;
  assign w_sat = ovf(w_rho) || ovf(w_jx) || ovf(w_jy);

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_s1_valid <= 1'b0;
      r_ra <= '0;
      r_rb <= '0;
      r_rc <= '0;
      r_xp <= '0;
      r_xn <= '0;
      r_yp <= '0;
      r_yn <= '0;
    end else begin
      if (clr)
        r_s1_valid <= 1'b0;
      else if (w_adv1)
        r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_ra <= sx(w_f[0]) + sx(w_f[1]) + sx(w_f[2]);
        r_rb <= sx(w_f[3]) + sx(w_f[4]) + sx(w_f[5]);
        r_rc <= sx(w_f[6]) + sx(w_f[7]) + sx(w_f[8]);
        r_xp <= sx(w_f[1]) + sx(w_f[5]) + sx(w_f[8]);
        r_xn <= sx(w_f[3]) + sx(w_f[6]) + sx(w_f[7]);
        r_yp <= sx(w_f[2]) + sx(w_f[5]) + sx(w_f[6]);
        r_yn <= sx(w_f[4]) + sx(w_f[7]) + sx(w_f[8]);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_out_valid <= 1'b0;
      r_rho <= '0;
      r_jx  <= '0;
      r_jy  <= '0;
      r_sat <= 1'b0;
    end else begin
      if (clr)
        r_out_valid <= 1'b0;
      else if (w_adv2)
        r_out_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_rho <= sat(w_rho);
        r_jx  <= sat(w_jx);
        r_jy  <= sat(w_jy);
      end
      if (clr)
        r_sat <= 1'b0;
      else if (w_s2_load && w_sat)
        r_sat <= 1'b1;
    end
  end

  assign w_out_fire = r_out_valid && out_ready;
  assign w_last     = r_out_valid && (r_addr == LAST);
  assign w_rho_ext  = {{(ACC_WIDTH-DW){r_rho[DW-1]}}, r_rho};

  // mass_total and frame_count survive clr; only RESET clears them
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_addr       <= '0;
      r_acc        <= '0;
      r_mass_total <= '0;
      r_mass_valid <= 1'b0;
      r_frames     <= '0;
    end else begin
      r_mass_valid <= 1'b0;
      if (clr) begin
        r_addr <= '0;
        r_acc  <= '0;
      end else if (w_out_fire) begin
        if (w_last) begin
          r_addr       <= '0;
          r_acc        <= '0;
          r_mass_total <= r_acc + w_rho_ext;
          r_frames     <= r_frames + 16'd1;
          r_mass_valid <= 1'b1;
        end else begin
          r_addr <= r_addr + AW'(1);
          r_acc  <= r_acc + w_rho_ext;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign rho_out     = r_rho;
  assign jx_out      = r_jx;
  assign jy_out      = r_jy;
  assign cell_addr   = r_addr;
  assign out_last    = w_last;
  assign mass_total  = r_mass_total;
  assign mass_valid  = r_mass_valid;
  assign frame_count = r_frames;
  assign sat_err     = r_sat;

endmodule

// File: tb/tb_lbm_moment_pipe.sv
// tb_lbm_moment_pipe: vector table plus scoreboard bench for lbm_moment_pipe
// covering latency, saturation, backpressure, frame mass and reset/clr.
module tb_lbm_moment_pipe;

  localparam int DW  = 32;
  localparam int FW  = 9 * DW;
  localparam int AW  = 8;
  localparam int ACW = 40;

  logic           CLOCK_50 = 1'b0;
  logic           RESET = 1'b0;
  logic           clr = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [FW-1:0]  fin_in = '0;
  logic           in_ready;
  logic           out_valid;
  logic [DW-1:0]  rho_out, jx_out, jy_out;
  logic [AW-1:0]  cell_addr;
  logic           out_last;
  logic [ACW-1:0] mass_total;
  logic           mass_valid;
  logic [15:0]    frame_count;
  logic           sat_err;

  always #5 CLOCK_50 = ~CLOCK_50;

  lbm_moment_pipe #(
    .GRID_DIM(256),
    .DATA_WIDTH(DW),
    .FRACTIONAL_BITS(24)
  ) u_dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fin_in(fin_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rho_out(rho_out),
    .jx_out(jx_out),
    .jy_out(jy_out),
    .cell_addr(cell_addr),
    .out_last(out_last),
    .mass_total(mass_total),
    .mass_valid(mass_valid),
    .frame_count(frame_count),
    .sat_err(sat_err)
  );

  typedef struct {
    logic [DW-1:0] rho;
    logic [DW-1:0] jx;
    logic [DW-1:0] jy;
  } res_t;

  typedef struct {
    logic [FW-1:0] fin;
    res_t          r;
  } vec_t;

  res_t           q[$];
  res_t           z = '{default: '0};
  vec_t           tv[8];
  int             n_cmp = 0;
  int             n_err = 0;
  int             n_pulse = 0;
  int             n_out = 0;
  logic [AW-1:0]  m_addr = '0;
  logic [ACW-1:0] m_acc = '0;
  logic [ACW-1:0] exp_mass = '0;
  logic [15:0]    exp_frames = '0;
  bit             mass_pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] pk9(
    input logic [DW-1:0] a0, input logic [DW-1:0] a1,
    input logic [DW-1:0] a2, input logic [DW-1:0] a3,
    input logic [DW-1:0] a4, input logic [DW-1:0] a5,
    input logic [DW-1:0] a6, input logic [DW-1:0] a7,
    input logic [DW-1:0] a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic res_t model(input logic [FW-1:0] f);
    longint v[9];
    longint s[3];
    res_t   r;
    for (int i = 0; i < 9; i++)
      v[i] = longint'($signed(f[i*DW +: DW]));
    s[0] = v[0] + v[1] + v[2] + v[3] + v[4] + v[5] + v[6] + v[7] + v[8];
    s[1] = v[1] + v[5] + v[8] - v[3] - v[6] - v[7];
    s[2] = v[2] + v[5] + v[6] - v[4] - v[7] - v[8];
    for (int i = 0; i < 3; i++) begin
      if (s[i] > 64'sd2147483647) s[i] = 64'sd2147483647;
      else if (s[i] < -64'sd2147483648) s[i] = -64'sd2147483648;
    end
    r.rho = 32'(s[0]);
    r.jx  = 32'(s[1]);
    r.jy  = 32'(s[2]);
    return r;
  endfunction

  always @(negedge CLOCK_50) begin
    res_t e;
    #2;
    if (mass_pend) begin
      chk("mass_valid", mass_valid, 1);
      chk("mass_total", mass_total, exp_mass);
      chk("frame_count", frame_count, exp_frames);
      mass_pend = 1'b0;
      n_pulse++;
    end else if (mass_valid) begin
      chk("mass_valid_spurious", mass_valid, 0);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rho", rho_out, e.rho);
        chk("jx", jx_out, e.jx);
        chk("jy", jy_out, e.jy);
        chk("cell_addr", cell_addr, m_addr);
        chk("out_last", out_last, m_addr == 8'd255);
        m_acc = m_acc + {{8{e.rho[31]}}, e.rho};
        if (m_addr == 8'd255) begin
          exp_mass = m_acc;
          m_acc = '0;
          exp_frames++;
          mass_pend = 1'b1;
          m_addr = '0;
        end else begin
          m_addr++;
        end
      end
    end
  end

  task automatic step(input bit v, input logic [FW-1:0] f, input res_t e,
                      input bit ordy, input bit c, output bit acc);
    @(negedge CLOCK_50);
    in_valid  = v;
    fin_in    = f;
    out_ready = ordy;
    clr       = c;
    #1;
    acc = v && in_ready;
    if (acc) q.push_back(e);
    if (c) begin
      q.delete();
      m_acc  = '0;
      m_addr = '0;
    end
  endtask

  task automatic send(input logic [FW-1:0] f, input bit ordy,
                      output bit acc);
    step(1'b1, f, model(f), ordy, 1'b0, acc);
  endtask

  task automatic idle(input bit ordy);
    bit a;
    step(1'b0, '0, z, ordy, 1'b0, a);
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || out_valid) && k < 200) begin
      idle(1'b1);
      k++;
    end
    chk("drain_left", q.size(), 0);
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic send_n(input int n, input logic [FW-1:0] f,
                        input bit rnd);
    int sent = 0;
    int t = 0;
    bit a;
    while (sent < n && t < 5000) begin
      send(f, rnd ? ($urandom_range(0, 3) != 0) : 1'b1, a);
      if (a) sent++;
      t++;
    end
    chk("send_n_count", sent, n);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] c1;
    logic [DW-1:0] held;
    bit            a;
    int            sent;
    int            o0;

    c1 = pk9(32'h0010_0000, 32'h0010_0000, 32'h0010_0000,
             32'h0010_0000, 32'h0010_0000, 32'h0010_0000,
             32'h0010_0000, 32'h0010_0000, 32'h0010_0000);
    tv[0] = '{c1, '{32'h0090_0000, 32'h0, 32'h0}};
    tv[1] = '{pk9(0, 32'h0100_0000, 0, 0, 0, 0, 0, 32'h0080_0000, 0),
              '{32'h0180_0000, 32'h0080_0000, 32'hFF80_0000}};
    tv[2] = '{{9{32'h7FFF_FFFF}},
              '{32'h7FFF_FFFF, 32'h0, 32'h0}};
    tv[3] = '{{9{32'h8000_0000}},
              '{32'h8000_0000, 32'h0, 32'h0}};
    tv[4] = '{pk9(0, 32'h7FFF_FFFF, 0, 0, 0, 32'h7FFF_FFFF, 0, 0,
                  32'h7FFF_FFFF),
              '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0}};
    tv[5] = '{pk9(0, 0, 0, 32'h8000_0000, 0, 0, 32'h8000_0000,
                  32'h8000_0000, 0),
              '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0}};
    tv[6] = '{pk9(0, 0, 32'h0020_0000, 0, 32'h0005_0000, 0, 0, 0, 0),
              '{32'h0025_0000, 32'h0, 32'h001B_0000}};
    tv[7] = '{pk9(32'hFFFF_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0003_0000),
              '{32'h0002_0000, 32'h0003_0000, 32'hFFFD_0000}};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rho", rho_out, 0);
    chk("rst_jx", jx_out, 0);
    chk("rst_jy", jy_out, 0);
    chk("rst_cell_addr", cell_addr, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_mass_total", mass_total, 0);
    chk("rst_mass_valid", mass_valid, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_sat_err", sat_err, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge CLOCK_50);
    RESET = 1'b1;

    step(1'b1, tv[0].fin, tv[0].r, 1'b1, 1'b0, a);
    chk("first_accept", a, 1);
    idle(1'b1);
    chk("lat_cycle1_valid", out_valid, 0);
    idle(1'b1);
    chk("lat_cycle2_valid", out_valid, 1);
    step(1'b1, tv[1].fin, tv[1].r, 1'b1, 1'b0, a);
    chk("accept_tv1", a, 1);
    drain();
    chk("sat_err_clean", sat_err, 0);

    for (int i = 2; i < 8; i++) begin
      step(1'b1, tv[i].fin, tv[i].r, 1'b1, 1'b0, a);
      chk("accept_tv", a, 1);
    end
    drain();
    chk("sat_err_set", sat_err, 1);
    idle(1'b1);
    chk("sat_err_sticky", sat_err, 1);
    step(1'b0, '0, z, 1'b0, 1'b1, a);
    idle(1'b1);
    chk("clr_sat_err", sat_err, 0);
    chk("clr_cell_addr", cell_addr, 0);

    sent = 0;
    o0 = n_out;
    held = '0;
    for (int t = 0; t < 40; t++) begin
      if (sent < 6) begin
        send(pk9(32'((sent + 1) << 16), 0, 0, 0, 0, 0, 0, 0, 0),
             !(t >= 2 && t < 7), a);
        if (a) sent++;
      end else begin
        idle(1'b1);
      end
      if (t == 3) held = rho_out;
      if (t == 6) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_rho_stable", rho_out, held);
      end
    end
    chk("stall_sent", sent, 6);
    chk("stall_outputs", n_out - o0, 6);
    chk("stall_queue_empty", q.size(), 0);

    step(1'b0, '0, z, 1'b0, 1'b1, a);
    n_pulse = 0;
    send_n(256, c1, 1'b1);
    drain();
    chk("frame_pulses", n_pulse, 1);
    chk("frame_count_1", frame_count, 1);
    chk("frame_mass", mass_total, 40'h00_9000_0000);
    chk("frame_next_addr", cell_addr, 0);

    send_n(100, c1, 1'b0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_count", frame_count, 0);
    q.delete();
    m_acc = '0;
    m_addr = '0;
    exp_frames = '0;
    mass_pend = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b1;
    n_pulse = 0;
    send_n(256, c1, 1'b0);
    drain();
    chk("rst_frame_pulses", n_pulse, 1);
    chk("rst_frame_count", frame_count, 1);
    chk("rst_frame_mass", mass_total, 40'h00_9000_0000);

    o0 = n_out;
    step(1'b1, c1, model(c1), 1'b0, 1'b1, a);
    chk("clr_no_accept", a, 0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("clr_no_output", n_out - o0, 0);
    chk("clr_keeps_mass", mass_total, 40'h00_9000_0000);
    chk("clr_keeps_frames", frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
